ram_arbiter: RTL

- Two-requester round-robin arbiter and sequencer in front of the single-port synchronous RAM (sync_ram: we/re/addr/din/dout, 16x8).
- Each requester issues one read or write per req/ack handshake.
- The block serialises accesses, drives the RAM strobes for exactly one cycle and returns read data with a single-cycle ack.

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/ram_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants, state encoding and helpers for the two-requester RAM arbiter.
// Optional grant statistics are enabled by defining RAM_ARB_STATS_EN.
package ram_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;
  localparam int STATS_W    = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACCESS  = 2'd1;
  localparam state_t ST_RD_WAIT = 2'd2;
  localparam state_t ST_RESP    = 2'd3;

  // Saturating increment used by the grant statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    if (v == {STATS_W{1'b1}}) begin
      return v;
    end else begin
      return v + STATS_W'(1);
    end
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. On a tie the requester that did
// not win last time is chosen; a lone requester always wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_idx
);

  // Select the winner from the current requests and the previous owner.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last_owner;
    end else if (req1) begin
      grant_idx = 1'b1;
    end else begin
      grant_idx = 1'b0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of a single-port
// synchronous RAM. Each accepted command drives one RAM strobe cycle and
// completes with a one-cycle ack (read data valid alongside the ack).
// Optional: define RAM_ARB_STATS_EN to add saturating per-requester grant
// counters gnt_cnt0/gnt_cnt1.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] gnt_cnt0,
  output logic [STATS_W-1:0] gnt_cnt1
`endif
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              grant_valid_s;
  logic              grant_idx_s;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Next-state and next-output logic for the access sequencer.
  // The ram_addr/ram_din/strobe registers double as the latched command.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          owner_d      = grant_idx_s;
          last_owner_d = grant_idx_s;
          if (grant_idx_s) begin
            ram_addr_d = addr1;
            ram_din_d  = wdata1;
            ram_we_d   = we1;
            ram_re_d   = ~we1;
          end else begin
            ram_addr_d = addr0;
            ram_din_d  = wdata0;
            ram_we_d   = we0;
            ram_re_d   = ~we0;
          end
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (ram_we_q) begin
          // Write is committed by the RAM on this edge; ack next cycle.
          state_d = ST_RESP;
          if (owner_q) begin
            ack1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
          end
        end else begin
          state_d = ST_RD_WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end

      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          // ram_dout is valid in this cycle; capture it with the ack.
          state_d = ST_RESP;
          if (owner_q) begin
            rdata1_d = ram_dout;
            ack1_d   = 1'b1;
          end else begin
            rdata0_d = ram_dout;
            ack0_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ram_we   = ram_we_q;
  assign ram_re   = ram_re_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign busy     = busy_q;

`ifdef RAM_ARB_STATS_EN
  logic [STATS_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [STATS_W-1:0] gnt_cnt1_q, gnt_cnt1_d;

  // Count each completed access per requester, saturating at all-ones.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (ack0_q) begin
      gnt_cnt0_d = sat_inc(gnt_cnt0_q);
    end else begin
      gnt_cnt0_d = gnt_cnt0_q;
    end
    if (ack1_q) begin
      gnt_cnt1_d = sat_inc(gnt_cnt1_q);
    end else begin
      gnt_cnt1_d = gnt_cnt1_q;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule
